// File: rtl/mem_preload_pkg.sv
// Shared types and helpers for the closely-coupled-memory preload controller.
// The checksum width is used only when MEM_PRELOAD_CHECKSUM_EN is defined.
package mem_preload_pkg;

    typedef enum logic [1:0] {
        OP_SETADDR = 2'd0,
        OP_WRITE   = 2'd1,
        OP_DONE    = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int CSUM_W = 32;

    // Widest supported word; callers truncate the mask to their own DataWidth.
    localparam int MAX_DW = 256;
    localparam int MAX_BE = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] be_to_mask(input logic [MAX_BE-1:0] be);
        logic [MAX_DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_BE; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_preload_csum.sv
// Running additive checksum over completed preload writes (address plus masked data).
// Instantiated by mem_preload_ctrl only when MEM_PRELOAD_CHECKSUM_EN is defined.
module mem_preload_csum
    import mem_preload_pkg::*;
#(
    parameter int AddrWidth = 11,
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 fold_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic [DataWidth-1:0] mask_i,
    output logic [CSUM_W-1:0]    csum_o
);

    logic [CSUM_W-1:0] csum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csum_q <= '0;
        end else if (fold_i) begin
            csum_q <= csum_q + CSUM_W'(addr_i) + CSUM_W'(data_i & mask_i);
        end
    end

    assign csum_o = csum_q;

endmodule

// File: rtl/mem_preload_ctrl.sv
// Command-driven preloader for the core's closely-coupled memories; holds the core in reset
// until the load is drained. Optional DONE checksum verification: MEM_PRELOAD_CHECKSUM_EN.
module mem_preload_ctrl
    import mem_preload_pkg::*;
#(
    parameter int  DataWidth = 32,
    parameter int  AddrWidth = 11,
    parameter int  Depth     = 2048,
    parameter int  NumMem    = 2,
    localparam int SelW      = (NumMem > 1) ? $clog2(NumMem) : 1,
    localparam int WordsW    = AddrWidth + $clog2(NumMem) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [SelW-1:0]        cmd_sel_i,
    input  logic [DataWidth-1:0]   cmd_data_i,
    input  logic [DataWidth/8-1:0] cmd_be_i,
    output logic [NumMem-1:0]      mem_we_o,
    input  logic [NumMem-1:0]      mem_gnt_i,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth-1:0]   mem_wmask_o,
    output logic                   core_rst_no,
    output logic                   finish_o,
    output logic                   err_o,
    output logic [WordsW-1:0]      words_o
);

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

    state_e                 state_q;
    logic                   live_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [SelW-1:0]        sel_q;
    logic                   inval_q;
    logic [NumMem-1:0]      we_q;
    logic [AddrWidth-1:0]   maddr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [DataWidth-1:0]   wmask_q;
    logic                   err_q;
    logic                   finish_q;
    logic                   core_rst_q;
    logic [WordsW-1:0]      words_q;

    op_e                    op;
    logic                   pend;
    logic                   pend_done;
    logic                   accept;
    logic                   setaddr_ok;
    logic [DataWidth-1:0]   beat_mask;
    logic [NumMem-1:0]      sel_onehot;

    assign op         = op_e'(cmd_op_i);
    // we_q is one-hot on the target memory, so it doubles as the pending flag.
    assign pend       = |we_q;
    assign pend_done  = |(we_q & mem_gnt_i);
    // live_q keeps ready low through reset and the first cycle after release.
    assign cmd_ready_o = live_q && (state_q == ST_LOAD) && (!pend || pend_done);
    assign accept     = cmd_valid_i && cmd_ready_o;
    assign setaddr_ok = ((DataWidth + 32)'(cmd_data_i) < (DataWidth + 32)'(Depth)) &&
                        (32'(cmd_sel_i) < 32'(NumMem));
    assign beat_mask  = DataWidth'(be_to_mask(MAX_BE'(cmd_be_i)));
    assign sel_onehot = NumMem'(1) << sel_q;

`ifdef MEM_PRELOAD_CHECKSUM_EN
    logic [CSUM_W-1:0] csum;
    logic [CSUM_W-1:0] done_csum_q;
    logic              csum_bad_q;

    mem_preload_csum #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) u_csum (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .fold_i (pend_done),
        .addr_i (maddr_q),
        .data_i (wdata_q),
        .mask_i (wmask_q),
        .csum_o (csum)
    );
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_LOAD;
            live_q     <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
            inval_q    <= 1'b0;
            we_q       <= '0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            err_q      <= 1'b0;
            finish_q   <= 1'b0;
            core_rst_q <= 1'b0;
            words_q    <= '0;
`ifdef MEM_PRELOAD_CHECKSUM_EN
            done_csum_q <= '0;
            csum_bad_q  <= 1'b0;
`endif
        end else begin
            live_q <= 1'b1;

            if (pend_done) begin
                we_q    <= '0;
                words_q <= words_q + 1'b1;
            end

            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        case (op)
                            OP_SETADDR: begin
                                if (setaddr_ok) begin
                                    addr_q  <= cmd_data_i[AddrWidth-1:0];
                                    sel_q   <= cmd_sel_i;
                                    inval_q <= 1'b0;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            OP_WRITE: begin
                                if (inval_q) begin
                                    err_q <= 1'b1;
                                end else begin
                                    // An all-zero byte enable skips the write but still advances.
                                    if (|cmd_be_i) begin
                                        we_q    <= sel_onehot;
                                        maddr_q <= addr_q;
                                        wdata_q <= cmd_data_i;
                                        wmask_q <= beat_mask;
                                    end
                                    if (addr_q == LastAddr) begin
                                        inval_q <= 1'b1;
                                    end else begin
                                        addr_q <= addr_q + 1'b1;
                                    end
                                end
                            end
                            OP_DONE: begin
                                state_q <= ST_DRAIN;
`ifdef MEM_PRELOAD_CHECKSUM_EN
                                done_csum_q <= CSUM_W'(cmd_data_i);
`endif
                            end
                            OP_RSVD: begin
                                err_q <= 1'b1;
                            end
                            default: begin
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_DRAIN: begin
                    if (!pend) begin
                        state_q <= ST_RUN;
`ifdef MEM_PRELOAD_CHECKSUM_EN
                        // Every write has been folded by now, so the sum is final.
                        if (csum != done_csum_q) begin
                            csum_bad_q <= 1'b1;
                            err_q      <= 1'b1;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    finish_q <= 1'b1;
`ifdef MEM_PRELOAD_CHECKSUM_EN
                    core_rst_q <= !csum_bad_q;
`else
                    core_rst_q <= 1'b1;
`endif
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = maddr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wmask_o = wmask_q;
    assign core_rst_no = core_rst_q;
    assign finish_o    = finish_q;
    assign err_o       = err_q;
    assign words_o     = words_q;

endmodule

// File: tb/tb_mem_preload_ctrl.sv
// Scoreboard bench for mem_preload_ctrl: a reference model predicts memory writes,
// error and word count from the command stream; a monitor checks writes as they are granted.
module tb_mem_preload_ctrl;
    import mem_preload_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;
    localparam int NM    = 2;
    localparam int WW    = AW + 1 + 1;
    localparam int EW    = 1 + AW + DW + DW;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic [1:0]      cmd_op_i;
    logic [0:0]      cmd_sel_i;
    logic [DW-1:0]   cmd_data_i;
    logic [DW/8-1:0] cmd_be_i;
    logic [NM-1:0]   mem_we_o;
    logic [NM-1:0]   mem_gnt_i;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [DW-1:0]   mem_wmask_o;
    logic            core_rst_no;
    logic            finish_o;
    logic            err_o;
    logic [WW-1:0]   words_o;

    mem_preload_ctrl #(
        .DataWidth (DW),
        .AddrWidth (AW),
        .Depth     (DEPTH),
        .NumMem    (NM)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_sel_i   (cmd_sel_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_be_i    (cmd_be_i),
        .mem_we_o    (mem_we_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wmask_o (mem_wmask_o),
        .core_rst_no (core_rst_no),
        .finish_o    (finish_o),
        .err_o       (err_o),
        .words_o     (words_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0] exp_q[$];

    // reference model state
    int          m_addr;
    int          m_sel;
    bit          m_valid;
    bit          m_err;
    int          m_words;
    logic [31:0] m_csum;

    bit gnt_low  = 1'b0;
    bit gnt_rand = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    task automatic model_reset();
        m_addr  = 0;
        m_sel   = 0;
        m_valid = 1'b1;
        m_err   = 1'b0;
        m_words = 0;
        m_csum  = 32'h0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [1:0] op, input logic [0:0] sel,
                                input logic [31:0] data, input logic [3:0] be);
        logic [31:0] mask;
        case (op)
            2'd0: begin
                if (data < DEPTH && int'(sel) < NM) begin
                    m_addr  = int'(data);
                    m_sel   = int'(sel);
                    m_valid = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            2'd1: begin
                if (!m_valid) begin
                    m_err = 1'b1;
                end else begin
                    if (be != 4'h0) begin
                        mask = ref_mask(be);
                        exp_q.push_back({1'(m_sel), AW'(m_addr), data, mask});
                        m_words++;
                        m_csum = m_csum + 32'(m_addr) + (data & mask);
                    end
                    m_addr++;
                    if (m_addr == DEPTH) m_valid = 1'b0;
                end
            end
            2'd2: ;
            default: m_err = 1'b1;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // Called and returning at posedge+1; a beat is taken when valid and ready are high at an edge.
    task automatic send(input logic [1:0] op, input logic [0:0] sel,
                        input logic [31:0] data, input logic [3:0] be);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_sel_i   = sel;
        cmd_data_i  = data;
        cmd_be_i    = be;
        while (!ok && t < 300) begin
            @(negedge clk_i);
            if (cmd_ready_o) ok = 1'b1;
            else t++;
        end
        if (ok) model_accept(op, sel, data, be);
        else check("send_ready_timeout", cmd_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        cmd_valid_i = 1'b0;
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    cmd_ready_o, 1'b0);
        check({tag, "_we"},       mem_we_o, 2'b00);
        check({tag, "_addr"},     mem_addr_o, '0);
        check({tag, "_wdata"},    mem_wdata_o, '0);
        check({tag, "_wmask"},    mem_wmask_o, '0);
        check({tag, "_core_rst"}, core_rst_no, 1'b0);
        check({tag, "_finish"},   finish_o, 1'b0);
        check({tag, "_err"},      err_o, 1'b0);
        check({tag, "_words"},    words_o, '0);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mem_we_o != '0) && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        check({tag, "_drain_queue"}, exp_q.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    // DONE carries the model checksum; with exact set, finish must rise exactly two cycles later.
    task automatic finish_load(input string tag, input bit exact, input logic [31:0] payload,
                               input bit exp_core);
        int t;
        send(OP_DONE, 1'b0, payload, 4'h0);
        if (exact) begin
            @(negedge clk_i);
            check({tag, "_finish_c1"}, finish_o, 1'b0);
            @(negedge clk_i);
            check({tag, "_finish_c2"}, finish_o, 1'b0);
            @(negedge clk_i);
        end else begin
            t = 0;
            while (!finish_o && t < 200) begin
                @(negedge clk_i);
                t++;
            end
        end
        check({tag, "_finish"}, finish_o, 1'b1);
        check({tag, "_core_rst"}, core_rst_no, exp_core);
        check({tag, "_words"}, words_o, WW'(m_words));
        check({tag, "_err"}, err_o, m_err);
        // commands are ignored once running
        cmd_valid_i = 1'b1;
        cmd_op_i    = OP_WRITE;
        cmd_be_i    = 4'hF;
        @(negedge clk_i);
        check({tag, "_run_ready"}, cmd_ready_o, 1'b0);
        @(negedge clk_i);
        check({tag, "_run_we"}, mem_we_o, 2'b00);
        cmd_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- grant driver ----------------
    initial begin
        mem_gnt_i = '1;
        forever begin
            @(posedge clk_i);
            #2;
            if (gnt_low)       mem_gnt_i = '0;
            else if (gnt_rand) mem_gnt_i = 2'($urandom);
            else               mem_gnt_i = '1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [127:0]  prev;
        logic [127:0]  cur;
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        bit hold;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                hold = 1'b0;
            end else begin
                cur = 128'({mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o});
                if (hold) check("write_hold_stable", cur, prev);
                hold = 1'b0;
                if (mem_we_o != '0) begin
                    check("we_onehot", $onehot(mem_we_o), 1'b1);
                    if ((mem_we_o & mem_gnt_i) != '0) begin
                        got = {mem_we_o[1], mem_addr_o, mem_wdata_o, mem_wmask_o};
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_write: got %0h expected none", got);
                        end else begin
                            exp = exp_q.pop_front();
                            check("write_beat", got, exp);
                        end
                    end else begin
                        hold = 1'b1;
                        prev = cur;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] t1_words [10];

    initial begin
        int r;
        logic [31:0] d;
        t1_words = '{32'h40000437, 32'h00a00e13, 32'h00000093, 32'h00100113, 32'h002081b3,
                     32'hfe0e1ee3, 32'h00c0006f, 32'hdeadbeef, 32'h12345678, 32'h00000fff};
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'd0;
        cmd_sel_i   = 1'b0;
        cmd_data_i  = '0;
        cmd_be_i    = '0;
        model_reset();
        #3;
        check_reset_outputs("por");

        // 1: straight ten-word load into memory 0, grant always high
        do_reset();
        send(OP_SETADDR, 1'b0, 32'd0, 4'h0);
        for (int i = 0; i < 10; i++) send(OP_WRITE, 1'b0, t1_words[i], 4'hF);
        finish_load("t1", 1'b1, m_csum, 1'b1);
        check("t1_words_const", words_o, WW'(10));

        // 2: grant stall on memory 1, then randomized traffic with random grants
        do_reset();
        gnt_low = 1'b1;
        send(OP_SETADDR, 1'b1, 32'd5, 4'h0);
        send(OP_WRITE, 1'b1, 32'hcafe0001, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("t2_stall_ready", cmd_ready_o, 1'b0);
            check("t2_stall_we", mem_we_o, 2'b10);
            check("t2_stall_addr", mem_addr_o, AW'(5));
        end
        @(posedge clk_i);
        #1;
        gnt_low  = 1'b0;
        gnt_rand = 1'b1;
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                d = (r < 2) ? 32'($urandom_range(2040, 2047)) : 32'($urandom_range(0, 2100));
                send(OP_SETADDR, 1'($urandom_range(0, 1)), d, 4'h0);
            end else if (r < 5) begin
                send(OP_RSVD, 1'b0, $urandom, 4'h0);
            end else begin
                send(OP_WRITE, 1'b0, $urandom, 4'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk_i);
                #1;
            end
        end
        gnt_rand = 1'b0;
        wait_drain("t2");
        check("t2_err", err_o, m_err);
        check("t2_words", words_o, WW'(m_words));
        finish_load("t2", 1'b0, m_csum, 1'b1);

        // 3: end of memory, second write dropped
        do_reset();
        send(OP_SETADDR, 1'b0, 32'd2047, 4'h0);
        @(negedge clk_i);
        check("t3_err_before", err_o, 1'b0);
        @(posedge clk_i);
        #1;
        send(OP_WRITE, 1'b0, 32'h11111111, 4'hF);
        send(OP_WRITE, 1'b0, 32'h22222222, 4'hF);
        wait_drain("t3");
        check("t3_err", err_o, 1'b1);
        check("t3_words", words_o, WW'(1));
        check("t3_model_words", words_o, WW'(m_words));

        // 4: out-of-range SETADDR keeps the old address; partial byte enables
        do_reset();
        send(OP_SETADDR, 1'b0, 32'h800, 4'h0);
        @(negedge clk_i);
        check("t4_err", err_o, 1'b1);
        @(posedge clk_i);
        #1;
        send(OP_WRITE, 1'b0, 32'ha5a5a5a5, 4'b0101);
        @(negedge clk_i);
        check("t4_we", mem_we_o, 2'b01);
        check("t4_addr", mem_addr_o, AW'(0));
        check("t4_mask", mem_wmask_o, 32'h00FF00FF);
        @(posedge clk_i);
        #1;
        send(OP_WRITE, 1'b0, 32'h0badf00d, 4'h0);
        send(OP_WRITE, 1'b0, 32'h600df00d, 4'b1000);
        wait_drain("t4");
        check("t4_words", words_o, WW'(m_words));

        // 5: reset while a write is pending, then a fresh load
        do_reset();
        send(OP_SETADDR, 1'b1, 32'd100, 4'h0);
        send(OP_WRITE, 1'b1, 32'h01020304, 4'hF);
        send(OP_RSVD, 1'b0, 32'h0, 4'h0);
        gnt_low = 1'b1;
        send(OP_WRITE, 1'b1, 32'h05060708, 4'hF);
        @(negedge clk_i);
        check("t5_pending_we", mem_we_o, 2'b10);
        check("t5_pre_err", err_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        model_reset();
        gnt_low = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        send(OP_SETADDR, 1'b0, 32'd7, 4'h0);
        for (int i = 0; i < 4; i++) send(OP_WRITE, 1'b0, $urandom, 4'hF);
        finish_load("t5", 1'b1, m_csum, 1'b1);

`ifdef MEM_PRELOAD_CHECKSUM_EN
        // 6: DONE checksum verification
        do_reset();
        send(OP_SETADDR, 1'b0, 32'd3, 4'h0);
        for (int i = 0; i < 3; i++) send(OP_WRITE, 1'b0, $urandom, 4'($urandom_range(1, 15)));
        m_err = 1'b1;
        finish_load("t6_bad", 1'b0, m_csum ^ 32'h1, 1'b0);
        do_reset();
        send(OP_SETADDR, 1'b0, 32'd3, 4'h0);
        for (int i = 0; i < 3; i++) send(OP_WRITE, 1'b0, $urandom, 4'($urandom_range(1, 15)));
        finish_load("t6_good", 1'b0, m_csum, 1'b1);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_preload_ctrl.md
Name: mem_preload_ctrl

Overview:
Hardware program/data loader that replaces ad-hoc bench-driven preload of the core's closely-coupled memories.
- Accepts a valid/ready command stream (set-address, write, done).
- Writes words with byte masks into one of NumMem memories (ICCM = 0, DCCM = 1, ...), auto-incrementing the address.
- Holds the core in reset until the load is complete and drained, then asserts finish.
- Sits between the external loader interface and the memory write ports inside top_core.

Parameters:
DataWidth, 32, word width; must equal top_pkg::TL_DW and be a multiple of 8.
AddrWidth, 11, word-address width per memory.
Depth, 2048, words per memory; must satisfy Depth <= 2**AddrWidth.
NumMem, 2, number of target memories; must be >= 1.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
cmd_valid_i  in  1  command beat valid.
cmd_ready_o  out  1  command beat accepted when valid and ready are both high.
cmd_op_i  in  2  0 = SETADDR, 1 = WRITE, 2 = DONE, 3 = reserved.
cmd_sel_i  in  $clog2(NumMem) (min 1)  target memory index, used by SETADDR.
cmd_data_i  in  DataWidth  address (SETADDR), write data (WRITE), or checksum (DONE).
cmd_be_i  in  DataWidth/8  byte enables for WRITE.
mem_we_o  out  NumMem  one-hot write request, held until granted.
mem_gnt_i  in  NumMem  per-memory write grant.
mem_addr_o  out  AddrWidth  write word address.
mem_wdata_o  out  DataWidth  write data.
mem_wmask_o  out  DataWidth  bit mask expanded from byte enables.
core_rst_no  out  1  core reset, active-low.
finish_o  out  1  load complete (level).
err_o  out  1  sticky error.
words_o  out  AddrWidth+$clog2(NumMem)+1  count of completed writes.

Behaviour:
Reset values: cmd_ready_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, mem_wmask_o = 0, core_rst_no = 0, finish_o = 0, err_o = 0, words_o = 0. Internal addr_q = 0, sel_q = 0, state = LOAD.

FSM states: LOAD, DRAIN, RUN.
- LOAD:
  - cmd_ready_o = !pend_q || mem_gnt_i[pend_sel_q].
  - A new beat may be accepted in the same cycle a pending write is granted (zero-bubble, one write per cycle).
- SETADDR:
  - addr_q <= cmd_data_i[AddrWidth-1:0]; sel_q <= cmd_sel_i.
  - If cmd_data_i >= Depth or cmd_sel_i >= NumMem: set err_o; addr_q and sel_q are unchanged.
- WRITE:
  - If addr_q is valid: register the write with pend_q = 1, mem_we_o[sel_q] = 1, and addr/data/mask driven from registers on the next cycle.
  - Then addr_q <= addr_q + 1.
  - Increment from Depth-1 does not wrap: an invalid flag is set, further WRITEs are dropped and set err_o until the next valid SETADDR.
  - cmd_be_i = 0: no mem_we_o asserted; the address still increments; words_o is unchanged.
- Write hold: mem_we_o, addr, data and mask are held stable until the matching mem_gnt_i is high; the write completes on that edge and words_o increments.
- DONE: accepted in LOAD, transitions to DRAIN. cmd_ready_o = 0 from that point on.
- DRAIN: wait until !pend_q, then go to RUN.
- RUN:
  - finish_o = 1 and core_rst_no = 1, both registered, rising one cycle after the drain completes.
  - cmd_ready_o = 0 permanently. Any cmd_valid_i is ignored.
- Reserved op: accepted and discarded; sets err_o.
- Reset mid-operation: all state returns to reset values immediately (async); a pending write is abandoned and the core is held in reset again.

Optional Feature:
Macro: MEM_PRELOAD_CHECKSUM_EN.
- Defined:
  - A running 32-bit additive checksum (mod 2^32) of {addr, masked data} folded per completed write.
  - DONE compares cmd_data_i with the final checksum after drain; a mismatch sets err_o and keeps core_rst_no = 0, while finish_o still rises.
- Undefined: DONE payload is ignored and no checksum logic is present.

Decomposition:
- Package mem_preload_pkg: op enum (OP_SETADDR, OP_WRITE, OP_DONE, OP_RSVD), state enum (ST_LOAD, ST_DRAIN, ST_RUN), a byte-enable-to-bitmask function, and the checksum width constant.
- Sub-module mem_preload_csum: checksum accumulator, instantiated only under the macro.

Test Plan:
1. SETADDR sel=0 addr=0; WRITE 10 words 0x40000437, 0x00a00e13, ... 0x00000fff with be=0xF; grant always high -> addresses 0..9, one write per cycle, mask=0xFFFFFFFF, words_o=10. DONE -> finish_o and core_rst_no high 2 cycles after DONE accepted.
2. Grant held low 5 cycles on memory 1 -> mem_we_o[1], addr and data stable; cmd_ready_o=0; no write is lost.
3. SETADDR addr=2047; 2 WRITEs -> first written at 2047, second dropped, err_o=1, words_o=1.
4. SETADDR addr=0x800 -> err_o=1, addr_q unchanged. be=0b0101 -> mask=0x00FF00FF.
5. rst_ni pulled low while a write is pending -> outputs return to reset values immediately; a fresh load then succeeds.
6. (Macro on) DONE with the wrong checksum -> err_o=1, core_rst_no stays 0. DONE with the correct checksum -> core_rst_no=1.
